mult_add_sched: RTL and testbench

- Round-robin scheduler that shares one mult_add datapath (pipelined multiply, then add/sub stage) among NUM_REQ requesters.
- Issues at most one operation per cycle. Aligns the C operand to the multiply-stage latency and tracks each in-flight operation with a tag pipeline.
- Returns the aligned multiply and add results to the issuing requester with a valid strobe.
- Sits between the requester fabric and a single mult_add instance.

---
 rtl/mult_add_pkg.sv | 25 ++
 rtl/mult_add_sched_rr_arbiter.sv | 50 +++++
 rtl/mult_add_sched.sv | 166 ++++++++++++++++
 tb/tb_mult_add_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_pkg.sv
// Shared constants, tag type and helpers for the mult_add request scheduler.
package mult_add_pkg;

    localparam int MULT_LAT  = 5;
    localparam int ADD_LAT   = 7;
    localparam int TOTAL_LAT = MULT_LAT + ADD_LAT + 1;

    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap,
// plus the pointer value to load after a grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               hold,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_vld,
    output logic [IDW-1:0]     next_ptr
);
    import mult_add_pkg::*;

    logic [IDW:0]   sum_s;
    logic [IDW-1:0] idx_s;
    logic           take_s;

    // Priority search from ptr; the extra sum bit handles non-power-of-2 wrap.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        take_s    = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s  = {1'b0, ptr} + (IDW+1)'(off);
            sum_s  = (sum_s >= (IDW+1)'(NUM_REQ)) ? (sum_s - (IDW+1)'(NUM_REQ)) : sum_s;
            idx_s  = sum_s[IDW-1:0];
            take_s = !grant_vld && !hold && req[idx_s];
            grant[idx_s] = grant[idx_s] | take_s;
            grant_id     = take_s ? idx_s : grant_id;
            grant_vld    = grant_vld | take_s;
        end
    end

    // Pointer moves one past the winner; no grant leaves it where it was.
    always_comb begin
        next_ptr = ptr;
        if (grant_vld) begin
            next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : (grant_id + IDW'(1));
        end else begin
            next_ptr = ptr;
        end
    end

endmodule

// File: rtl/mult_add_sched.sv
// Shares one mult_add datapath among NUM_REQ requesters: round-robin issue,
// C-operand alignment, in-flight tag tracking and registered responses.
module mult_add_sched #(
    parameter int PRECISION = 32,
    parameter int NUM_REQ   = 4,
    parameter int MULT_LAT  = mult_add_pkg::MULT_LAT,
    parameter int ADD_LAT   = mult_add_pkg::ADD_LAT,
    parameter int IDW       = mult_add_pkg::clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PRECISION-1:0]   req_a,
    input  logic [NUM_REQ*PRECISION-1:0]   req_b,
    input  logic [NUM_REQ*PRECISION-1:0]   req_c,
    output logic [PRECISION-1:0]           dp_a,
    output logic [PRECISION-1:0]           dp_b,
    output logic [PRECISION-1:0]           dp_c,
    input  logic [PRECISION-1:0]           dp_mult_result,
    input  logic [PRECISION-1:0]           dp_add_result,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [PRECISION-1:0]           rsp_mult,
    output logic [PRECISION-1:0]           rsp_add,
    output logic                           busy,
    output logic [IDW+3:0]                 inflight
);
    import mult_add_pkg::*;

    localparam int DEPTH = MULT_LAT + ADD_LAT + 1;
    localparam int MDLY  = ADD_LAT + 1;
    localparam int CW    = IDW + 4;

    logic [NUM_REQ-1:0]   grant_s;
    logic [IDW-1:0]       grant_id_s;
    logic                 grant_vld_s;
    logic [IDW-1:0]       next_ptr_s;
    logic [PRECISION-1:0] sel_a_s, sel_b_s, sel_c_s;
    logic                 retire_s;

    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PRECISION-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, c_issue_q, c_issue_d;
    logic [PRECISION-1:0] c_dly_q [MULT_LAT];
    logic [PRECISION-1:0] c_dly_d [MULT_LAT];
    tag_t                 tag_q [DEPTH];
    tag_t                 tag_d [DEPTH];
    tag_t                 rsp_pend_q, rsp_pend_d;
    logic [PRECISION-1:0] mult_q [MDLY];
    logic [PRECISION-1:0] mult_d [MDLY];
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [PRECISION-1:0] rsp_mult_q, rsp_mult_d, rsp_add_q, rsp_add_d;
    logic [CW-1:0]        inflight_q, inflight_d;

    // Reset also masks grants so req_ready is quiet while rst is high.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .hold      (hold | rst),
        .grant     (grant_s),
        .grant_id  (grant_id_s),
        .grant_vld (grant_vld_s),
        .next_ptr  (next_ptr_s)
    );

    // AND-OR operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        sel_c_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | ({PRECISION{grant_s[i]}} & req_a[i*PRECISION +: PRECISION]);
            sel_b_s = sel_b_s | ({PRECISION{grant_s[i]}} & req_b[i*PRECISION +: PRECISION]);
            sel_c_s = sel_c_s | ({PRECISION{grant_s[i]}} & req_c[i*PRECISION +: PRECISION]);
        end
    end

    // Issue register, C delay line, tag pipeline and product delay line.
    always_comb begin
        rr_ptr_d   = next_ptr_s;
        dp_a_d     = grant_vld_s ? sel_a_s : dp_a_q;
        dp_b_d     = grant_vld_s ? sel_b_s : dp_b_q;
        c_issue_d  = grant_vld_s ? sel_c_s : c_issue_q;
        c_dly_d[0] = c_issue_q;
        for (int i = 1; i < MULT_LAT; i++) begin
            c_dly_d[i] = c_dly_q[i-1];
        end
        tag_d[0].valid = grant_vld_s;
        tag_d[0].id    = TAG_IDW'(grant_id_s);
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        // The tag leaving the pipeline lines up with dp_add_result one cycle on.
        rsp_pend_d = tag_q[DEPTH-1];
        mult_d[0]  = dp_mult_result;
        for (int i = 1; i < MDLY; i++) begin
            mult_d[i] = mult_q[i-1];
        end
    end

    // Response register contents and in-flight count.
    always_comb begin
        retire_s = tag_q[DEPTH-1].valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_pend_q.valid && (rsp_pend_q.id == TAG_IDW'(i));
        end
        rsp_id_d   = rsp_pend_q.valid ? rsp_pend_q.id[IDW-1:0] : rsp_id_q;
        rsp_mult_d = rsp_pend_q.valid ? mult_q[MDLY-1]         : rsp_mult_q;
        rsp_add_d  = rsp_pend_q.valid ? dp_add_result          : rsp_add_q;
        case ({grant_vld_s, retire_s})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; async reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            c_issue_q   <= '0;
            for (int i = 0; i < MULT_LAT; i++) c_dly_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++)    tag_q[i]   <= '0;
            for (int i = 0; i < MDLY; i++)     mult_q[i]  <= '0;
            rsp_pend_q  <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_mult_q  <= '0;
            rsp_add_q   <= '0;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            c_issue_q   <= c_issue_d;
            c_dly_q     <= c_dly_d;
            tag_q       <= tag_d;
            mult_q      <= mult_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_mult_q  <= rsp_mult_d;
            rsp_add_q   <= rsp_add_d;
            inflight_q  <= inflight_d;
        end
    end

    assign req_ready = grant_s;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_c      = c_dly_q[MULT_LAT-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_mult  = rsp_mult_q;
    assign rsp_add   = rsp_add_q;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0) | grant_vld_s;

endmodule

// File: tb/tb_mult_add_sched.sv
// Directed bench for mult_add_sched with a behavioural mult_add datapath model.
module tb_mult_add_sched;

    localparam int P   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             hold;
    logic [N-1:0]     req_valid, req_ready, rsp_valid;
    logic [N*P-1:0]   req_a, req_b, req_c;
    logic [P-1:0]     dp_a, dp_b, dp_c, dp_mult_result, dp_add_result;
    logic [P-1:0]     rsp_mult, rsp_add;
    logic [IDW-1:0]   rsp_id;
    logic             busy;
    logic [IDW+3:0]   inflight;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_add_sched dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_c          (req_c),
        .dp_a           (dp_a),
        .dp_b           (dp_b),
        .dp_c           (dp_c),
        .dp_mult_result (dp_mult_result),
        .dp_add_result  (dp_add_result),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_mult       (rsp_mult),
        .rsp_add        (rsp_add),
        .busy           (busy),
        .inflight       (inflight)
    );

    // mult_add model: 5-cycle multiply, add-stage input regs, then 7 cycles to the sum.
    logic [P-1:0] m_pipe [5];
    logic [P-1:0] add_in_c, add_in_m;
    logic [P-1:0] a_pipe [7];
    always @(posedge clk) begin
        m_pipe[0] <= dp_a * dp_b;
        for (int i = 1; i < 5; i++) m_pipe[i] <= m_pipe[i-1];
        add_in_c  <= dp_c;
        add_in_m  <= dp_mult_result;
        a_pipe[0] <= add_in_c + add_in_m;
        for (int i = 1; i < 7; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign dp_mult_result = m_pipe[4];
    assign dp_add_result  = a_pipe[6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [P-1:0] a, input logic [P-1:0] b, input logic [P-1:0] c);
        req_a[i*P +: P] = a;
        req_b[i*P +: P] = b;
        req_c[i*P +: P] = c;
    endtask

    logic [3:0] hold_exp [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1,
                                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                  4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int rsp_cnt;
        rst = 1'b1; hold = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 64'h0);
        check("rst_rsp_valid", rsp_valid, 64'h0);
        check("rst_rsp_id", rsp_id, 64'h0);
        check("rst_rsp_mult", rsp_mult, 64'h0);
        check("rst_rsp_add", rsp_add, 64'h0);
        check("rst_busy", busy, 64'h0);
        check("rst_inflight", inflight, 64'h0);
        check("rst_dp_a", dp_a, 64'h0);
        check("rst_dp_c", dp_c, 64'h0);
        rst = 1'b0;
        tick();

        // Fairness: all four valid for 16 cycles.
        for (int i = 0; i < N; i++) set_op(i, P'(i + 1), 32'd10, P'(i));
        for (int c = 0; c < 32; c++) begin
            req_valid = (c < 16) ? 4'hF : 4'h0;
            #1;
            check("fair_grant", req_ready, (c < 16) ? (64'd1 << (c % 4)) : 64'd0);
            if (c >= 13 && c <= 15) begin
                check("steady_inflight", inflight, 64'd13);
                check("steady_busy", busy, 64'd1);
            end
            tick();
            if (c >= 14 && c <= 29) begin
                id = (c - 14) % 4;
                check("fair_rsp_valid", rsp_valid, 64'd1 << id);
                check("fair_rsp_id", rsp_id, 64'(id));
                check("fair_rsp_mult", rsp_mult, 64'((id + 1) * 10));
                check("fair_rsp_add", rsp_add, 64'((id + 1) * 10 + id));
            end else begin
                check("fair_rsp_idle", rsp_valid, 64'h0);
            end
        end
        check("fair_drain_inflight", inflight, 64'h0);
        check("fair_drain_busy", busy, 64'h0);

        // hold for cycles 5..9 of a continuous stream.
        rsp_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            req_valid = 4'hF;
            hold = (c >= 5 && c <= 9);
            #1;
            check("hold_grant", req_ready, 64'(hold_exp[c]));
            tick();
            if (rsp_valid != 4'h0) rsp_cnt++;
        end
        req_valid = '0;
        hold = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid != 4'h0) rsp_cnt++;
        end
        check("hold_rsp_count", 64'(rsp_cnt), 64'd10);
        check("hold_drain_inflight", inflight, 64'h0);
        check("hold_drain_busy", busy, 64'h0);

        // Single operation from requester 2.
        set_op(2, 32'd3, 32'd5, 32'd7);
        req_valid = 4'b0100;
        #1;
        check("single_grant", req_ready, 64'h4);
        tick();
        req_valid = '0;
        check("single_inflight", inflight, 64'd1);
        check("single_busy", busy, 64'd1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("single_early", rsp_valid, 64'h0);
        end
        check("single_retired", inflight, 64'h0);
        tick();
        check("single_rsp_valid", rsp_valid, 64'h4);
        check("single_rsp_id", rsp_id, 64'd2);
        check("single_rsp_mult", rsp_mult, 64'd15);
        check("single_rsp_add", rsp_add, 64'd22);
        tick();
        check("single_once", rsp_valid, 64'h0);
        check("single_mult_hold", rsp_mult, 64'd15);
        check("single_add_hold", rsp_add, 64'd22);

        // C alignment: interleaved requesters 0 and 1 with distinct C.
        set_op(0, 32'd2, 32'd3, 32'd100);
        set_op(1, 32'd4, 32'd5, 32'd200);
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 4) ? 4'b0011 : 4'b0000;
            #1;
            check("calign_grant", req_ready, (c < 4) ? ((c % 2 == 0) ? 64'h1 : 64'h2) : 64'h0);
            tick();
            if (c >= 14 && c <= 17) begin
                id = (c - 14) % 2;
                check("calign_rsp_valid", rsp_valid, 64'd1 << id);
                check("calign_rsp_mult", rsp_mult, (id == 0) ? 64'd6 : 64'd20);
                check("calign_rsp_add", rsp_add, (id == 0) ? 64'd106 : 64'd220);
            end else begin
                check("calign_idle", rsp_valid, 64'h0);
            end
        end

        // Reset with three operations in flight.
        req_valid = 4'hF;
        repeat (3) tick();
        req_valid = '0;
        repeat (7) tick();
        check("prerst_inflight", inflight, 64'd3);
        rst = 1'b1;
        tick();
        tick();
        check("midrst_inflight", inflight, 64'h0);
        check("midrst_busy", busy, 64'h0);
        check("midrst_rsp_mult", rsp_mult, 64'h0);
        check("midrst_dp_a", dp_a, 64'h0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("postrst_no_rsp", rsp_valid, 64'h0);
        end
        check("postrst_inflight", inflight, 64'h0);
        check("postrst_busy", busy, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
